// File: rtl/node_if.sv
// Message bus between a search node, its upstream source and its neighbors.
interface node_if #(
  parameter int unsigned VAR_WIDTH     = 8,
  parameter int unsigned CLAUSE_LENGTH = 3,
  parameter int unsigned NUM_NEIGHBORS = 4
);
  logic [VAR_WIDTH-1:0]     incoming_var;
  logic                     incoming_var_valid;
  logic [1:0]               incoming_msg_type;
  logic [CLAUSE_LENGTH-1:0] incoming_mask;
  logic [NUM_NEIGHBORS-1:0] neighbor_busy;

  logic [VAR_WIDTH-1:0]     outgoing_var;
  logic                     outgoing_var_valid;
  logic [1:0]               outgoing_msg_type;
  logic [CLAUSE_LENGTH-1:0] outgoing_mask;
  logic [NUM_NEIGHBORS-1:0] node_busy;
  logic                     sat_found;

  modport master (
    output incoming_var, incoming_var_valid, incoming_msg_type, incoming_mask, neighbor_busy,
    input  outgoing_var, outgoing_var_valid, outgoing_msg_type, outgoing_mask, node_busy, sat_found
  );

  modport slave (
    input  incoming_var, incoming_var_valid, incoming_msg_type, incoming_mask, neighbor_busy,
    output outgoing_var, outgoing_var_valid, outgoing_msg_type, outgoing_mask, node_busy, sat_found
  );
endinterface

// File: rtl/node.sv
// SAT search node: accumulates clause results for a forked variable, forks the
// next variable to a free neighbor on a miss, and latches SAT once all clauses hold.
module node #(
  parameter int unsigned NODE_ID       = 0,
  parameter int unsigned NUM_NEIGHBORS = 4,
  parameter int unsigned CLAUSE_LENGTH = 3,
  parameter int unsigned NUM_CLAUSES   = 16,
  parameter int unsigned VAR_WIDTH     = 8
) (
  input logic clk,
  input logic rst_n,
  node_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_FORK = 2'b01;
  localparam logic [1:0] MSG_MASK = 2'b10;
  localparam logic [1:0] MSG_VNF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SOLVING = 2'b01,
    ST_FORK    = 2'b10,
    ST_SAT     = 2'b11
  } state_e;

  state_e                   current_state_q, current_state_d;
  logic [VAR_WIDTH-1:0]     var_reg_q, var_reg_d;
  logic [PTR_W-1:0]         clause_ptr_q, clause_ptr_d;
  logic [NUM_CLAUSES-1:0]   clause_sat_q, clause_sat_d;

  logic [VAR_WIDTH-1:0]     outgoing_var_q, outgoing_var_d;
  logic                     outgoing_var_valid_q, outgoing_var_valid_d;
  logic [1:0]               outgoing_msg_type_q, outgoing_msg_type_d;
  logic [CLAUSE_LENGTH-1:0] outgoing_mask_q, outgoing_mask_d;
  logic [NUM_NEIGHBORS-1:0] node_busy_q, node_busy_d;
  logic                     sat_found_q, sat_found_d;

  // The identifier does not affect behaviour; kept for instance bookkeeping.
  logic node_id_unused;
  assign node_id_unused = ^32'(NODE_ID);

  always_comb begin
    current_state_d      = current_state_q;
    var_reg_d            = var_reg_q;
    clause_ptr_d         = clause_ptr_q;
    clause_sat_d         = clause_sat_q;
    outgoing_var_d       = outgoing_var_q;
    outgoing_var_valid_d = 1'b0;
    outgoing_msg_type_d  = MSG_NONE;
    outgoing_mask_d      = '0;

    case (current_state_q)
      ST_IDLE: begin
        if (bus.incoming_msg_type == MSG_FORK && bus.incoming_var_valid) begin
          var_reg_d       = bus.incoming_var;
          clause_sat_d    = '0;
          clause_ptr_d    = '0;
          current_state_d = ST_SOLVING;
        end
      end
      ST_SOLVING: begin
        if (bus.incoming_msg_type == MSG_MASK) begin
          clause_sat_d[clause_ptr_q] = clause_sat_q[clause_ptr_q] | (|bus.incoming_mask);
          clause_ptr_d = (clause_ptr_q == PTR_W'(NUM_CLAUSES - 1)) ? '0
                                                                   : clause_ptr_q + PTR_W'(1);
          outgoing_msg_type_d = MSG_MASK;
          outgoing_mask_d     = bus.incoming_mask;
          if (&clause_sat_d) current_state_d = ST_SAT;
        end else if (bus.incoming_msg_type == MSG_VNF) begin
          // The last representable variable has no successor to fork.
          current_state_d = (&var_reg_q) ? ST_IDLE : ST_FORK;
        end
      end
      ST_FORK: begin
        if (!(&bus.neighbor_busy)) begin
          var_reg_d            = var_reg_q + VAR_WIDTH'(1);
          outgoing_var_d       = var_reg_q + VAR_WIDTH'(1);
          outgoing_var_valid_d = 1'b1;
          outgoing_msg_type_d  = MSG_FORK;
          current_state_d      = ST_SOLVING;
        end
      end
      ST_SAT: ;
      default: current_state_d = ST_IDLE;
    endcase

    node_busy_d = {NUM_NEIGHBORS{current_state_d != ST_IDLE}};
    sat_found_d = (current_state_d == ST_SAT);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      current_state_q      <= ST_IDLE;
      var_reg_q            <= '0;
      clause_ptr_q         <= '0;
      clause_sat_q         <= '0;
      outgoing_var_q       <= '0;
      outgoing_var_valid_q <= 1'b0;
      outgoing_msg_type_q  <= MSG_NONE;
      outgoing_mask_q      <= '0;
      node_busy_q          <= '0;
      sat_found_q          <= 1'b0;
    end else begin
      current_state_q      <= current_state_d;
      var_reg_q            <= var_reg_d;
      clause_ptr_q         <= clause_ptr_d;
      clause_sat_q         <= clause_sat_d;
      outgoing_var_q       <= outgoing_var_d;
      outgoing_var_valid_q <= outgoing_var_valid_d;
      outgoing_msg_type_q  <= outgoing_msg_type_d;
      outgoing_mask_q      <= outgoing_mask_d;
      node_busy_q          <= node_busy_d;
      sat_found_q          <= sat_found_d;
    end
  end

  assign bus.outgoing_var       = outgoing_var_q;
  assign bus.outgoing_var_valid = outgoing_var_valid_q;
  assign bus.outgoing_msg_type  = outgoing_msg_type_q;
  assign bus.outgoing_mask      = outgoing_mask_q;
  assign bus.node_busy          = node_busy_q;
  assign bus.sat_found          = sat_found_q;
endmodule

// File: tb/tb_node.sv
// Directed and randomized checks of node against a clause-counting reference model.
module tb_node;
  logic clk;
  logic rst_n;

  node_if #(.VAR_WIDTH(8), .CLAUSE_LENGTH(3), .NUM_NEIGHBORS(4)) bus ();

  node #(
    .NODE_ID(0), .NUM_NEIGHBORS(4), .CLAUSE_LENGTH(3), .NUM_CLAUSES(16), .VAR_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase names as ints, clause results kept as a set plus a count.
  int       m_phase;            // 0 idle, 1 solving, 2 waiting to fork, 3 sat
  int       m_var;
  int       m_ptr;
  bit       m_done [16];
  int       m_done_cnt;
  int       e_type, e_var, e_valid, e_mask;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input int t, input int v, input bit vv,
                            input int m, input int nb);
    e_type = 0; e_valid = 0; e_mask = 0;
    if (r) begin
      m_phase = 0; m_var = 0; m_ptr = 0; m_done_cnt = 0; e_var = 0;
      foreach (m_done[i]) m_done[i] = 0;
      return;
    end
    case (m_phase)
      0: if (t == 1 && vv) begin
           m_var = v; m_ptr = 0; m_done_cnt = 0; m_phase = 1;
           foreach (m_done[i]) m_done[i] = 0;
         end
      1: if (t == 2) begin
           if (m != 0 && !m_done[m_ptr]) begin
             m_done[m_ptr] = 1;
             m_done_cnt++;
           end
           m_ptr = (m_ptr + 1) % 16;
           e_type = 2; e_mask = m;
           if (m_done_cnt == 16) m_phase = 3;
         end else if (t == 3) begin
           m_phase = (m_var == 255) ? 0 : 2;
         end
      2: if (nb != 15) begin
           m_var = (m_var + 1) % 256;
           e_type = 1; e_var = m_var; e_valid = 1; m_phase = 1;
         end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int sat_vec;
    sat_vec = 0;
    for (int i = 0; i < 16; i++) if (m_done[i]) sat_vec |= (1 << i);
    check({tag, ".state"},     int'(dut.current_state_q), m_phase);
    check({tag, ".var_reg"},   int'(dut.var_reg_q),       m_var);
    check({tag, ".clause_ptr"},int'(dut.clause_ptr_q),    m_ptr);
    check({tag, ".clause_sat"},int'(dut.clause_sat_q),    sat_vec);
    check({tag, ".node_busy"}, int'(bus.node_busy),       (m_phase != 0) ? 15 : 0);
    check({tag, ".sat_found"}, int'(bus.sat_found),       (m_phase == 3) ? 1 : 0);
    check({tag, ".out_type"},  int'(bus.outgoing_msg_type),  e_type);
    check({tag, ".out_valid"}, int'(bus.outgoing_var_valid), e_valid);
    check({tag, ".out_mask"},  int'(bus.outgoing_mask),      e_mask);
    check({tag, ".out_var"},   int'(bus.outgoing_var),       e_var);
  endtask

  // Drive one cycle of inputs, step the model at the edge, check just after it.
  task automatic tick(input bit r, input int t, input int v, input bit vv,
                      input int m, input int nb, input string tag);
    rst_n                  = r;
    bus.incoming_msg_type  = 2'(t);
    bus.incoming_var       = 8'(v);
    bus.incoming_var_valid = vv;
    bus.incoming_mask      = 3'(m);
    bus.neighbor_busy      = 4'(nb);
    @(posedge clk);
    model_step(r, t, v, vv, m, nb);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.incoming_msg_type = 2'b00; bus.incoming_var = 8'h00;
    bus.incoming_var_valid = 1'b0; bus.incoming_mask = 3'b000; bus.neighbor_busy = 4'h0;
    m_phase = 0; m_var = 0; m_ptr = 0; m_done_cnt = 0;
    e_type = 0; e_var = 0; e_valid = 0; e_mask = 0;
    foreach (m_done[i]) m_done[i] = 0;

    // Reset, fork in, one mask, miss, fork out
    tick(1, 0, 0, 0, 0, 0, "rst0");
    tick(1, 1, 8'h99, 1, 7, 0, "rst1");
    tick(0, 1, 8'h42, 1, 0, 0, "fork_in");
    tick(0, 2, 0, 0, 3'b101, 0, "mask101");
    tick(0, 0, 0, 0, 0, 0, "mask_clear");
    tick(0, 1, 8'h10, 1, 0, 0, "solving_ignores_fork");
    tick(0, 3, 0, 0, 0, 0, "vnf");
    tick(0, 2, 0, 0, 7, 0, "fork_emit");
    tick(0, 0, 0, 0, 0, 0, "fork_strobe_end");

    // Fork blocked by busy neighbors, then released
    tick(0, 3, 0, 0, 0, 15, "vnf_busy");
    tick(0, 2, 0, 0, 5, 15, "fork_wait1");
    tick(0, 1, 8'h77, 1, 0, 15, "fork_wait2");
    tick(0, 0, 0, 0, 0, 4'b1011, "fork_release");
    tick(0, 0, 0, 0, 0, 0, "after_release");

    // Sixteen nonzero masks from a fresh fork reach SAT; SAT is sticky
    tick(1, 0, 0, 0, 0, 0, "rst_sat");
    tick(0, 1, 8'h05, 0, 0, 0, "fork_invalid_idle");
    tick(0, 1, 8'h05, 1, 0, 0, "fork_sat_run");
    for (int i = 0; i < 16; i++) tick(0, 2, 0, 0, (i % 7) + 1, 0, "sat_mask");
    tick(0, 3, 0, 0, 0, 0, "sat_vnf");
    tick(0, 1, 8'h01, 1, 0, 0, "sat_fork");
    tick(1, 2, 0, 0, 7, 0, "rst_in_sat");

    // Last variable value returns to idle on a miss
    tick(0, 1, 8'hff, 1, 0, 0, "fork_ff");
    tick(0, 3, 0, 0, 0, 0, "vnf_ff");
    // Reset during a blocked fork wait
    tick(0, 1, 8'h20, 1, 0, 15, "fork_20");
    tick(0, 3, 0, 0, 0, 15, "vnf_20");
    tick(1, 0, 0, 0, 0, 0, "rst_in_wait");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int t, v, m, nb;
      bit r, vv;
      r  = ($urandom_range(0, 149) == 0);
      t  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) t = 2;
      v  = ($urandom_range(0, 7) == 0) ? 8'hff - $urandom_range(0, 1) : $urandom_range(0, 255);
      vv = $urandom_range(0, 3) != 0;
      m  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7);
      nb = ($urandom_range(0, 1) == 0) ? 15 : $urandom_range(0, 15);
      tick(r, t, v, vv, m, nb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/node.md
NODE -- requirements
Module: node

Interface
REQ-001 Parameters (name, default, meaning): NODE_ID 0 node identifier; NUM_NEIGHBORS 4 neighbor count; CLAUSE_LENGTH 3 literals per clause; NUM_CLAUSES 16 clause slots; VAR_WIDTH 8 variable index width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; one clock, synchronous, active-high: rst_n=1 resets at the clock edge despite the suffix.
REQ-004 incoming_var  in  VAR_WIDTH  variable carried by an incoming FORK.
REQ-005 incoming_var_valid  in  1  qualifies incoming_var; required only for FORK.
REQ-006 incoming_msg_type  in  2  00 NONE, 01 FORK, 10 SUBSTITUTION_MASK, 11 VARIABLE_NOT_FOUND.
REQ-007 incoming_mask  in  CLAUSE_LENGTH  per-literal result for current clause; bit=1 means literal true.
REQ-008 neighbor_busy  in  NUM_NEIGHBORS  bit i=1 means neighbor i cannot accept a fork.
REQ-009 outgoing_var  out  VAR_WIDTH  variable of an emitted FORK.
REQ-010 outgoing_var_valid  out  1  one-cycle strobe qualifying an emitted FORK.
REQ-011 outgoing_msg_type  out  2  type of emitted message, same encoding as input; 00 when none.
REQ-012 outgoing_mask  out  CLAUSE_LENGTH  echoed substitution mask.
REQ-013 node_busy  out  NUM_NEIGHBORS  all bits = (current_state != IDLE).
REQ-014 sat_found  out  1  high while current_state == SAT.

Function
REQ-015 2-bit register current_state SHALL exist with encoding IDLE=00, SOLVING=01, FORK=10, SAT=11.
REQ-016 Internal registers: var_reg[VAR_WIDTH], clause_ptr[$clog2(NUM_CLAUSES)], clause_sat[NUM_CLAUSES].
REQ-017 Incoming messages sampled every edge; each cycle a type is present counts as one event.
REQ-018 IDLE: FORK with incoming_var_valid=1 loads var_reg=incoming_var, clears clause_sat, sets clause_ptr=0, goes SOLVING; FORK with valid=0 and all other types are ignored.
REQ-019 SOLVING, SUBSTITUTION_MASK: clause_sat[clause_ptr] |= (|incoming_mask); clause_ptr increments, wrapping from NUM_CLAUSES-1 to 0.
REQ-020 Same event: next edge drives outgoing_msg_type=10 and outgoing_mask=incoming_mask for one cycle, with outgoing_var_valid=0.
REQ-021 SOLVING: if all clause_sat bits are 1 after an update, next state is SAT.
REQ-022 SOLVING, VARIABLE_NOT_FOUND: if var_reg is all ones, go IDLE; else go FORK.
REQ-023 SOLVING: FORK messages are ignored.
REQ-024 FORK state: if any neighbor_busy bit is 0, next edge drives outgoing_msg_type=01, outgoing_var=var_reg+1, outgoing_var_valid=1 for one cycle, sets var_reg=var_reg+1, and returns to SOLVING.
REQ-025 FORK state: if neighbor_busy is all ones, remain in FORK with no output, indefinitely.
REQ-026 FORK state: all incoming messages are ignored.
REQ-027 SAT is sticky until reset; incoming messages are ignored; sat_found=1.
REQ-028 All outputs are registered, one cycle after the causing edge.
REQ-029 outgoing_msg_type, outgoing_var_valid and outgoing_mask return to 0 the cycle after an emission.
REQ-030 outgoing_var holds its last value.

Reset
REQ-031 While rst_n=1 at an edge: current_state=IDLE; var_reg, clause_ptr, clause_sat=0; all outputs 0, including node_busy, sat_found and outgoing_var.
REQ-032 Reset overrides any simultaneous message in any state, including mid-FORK wait and SAT.

Verification
REQ-033 Reset held 2 cycles, then FORK var=8'h42 valid=1 -> current_state=01, node_busy=4'b1111, var_reg=8'h42.
REQ-034 In SOLVING, mask 3'b101 -> clause_sat[0]=1, clause_ptr=1; next cycle outgoing_msg_type=10, outgoing_mask=3'b101.
REQ-035 VARIABLE_NOT_FOUND with neighbor_busy=0 -> state 10, then outgoing FORK var=8'h43 with valid=1 for exactly one cycle; state back to 01.
REQ-036 VARIABLE_NOT_FOUND with neighbor_busy=4'b1111 -> stays 10 with no output; then neighbor_busy=4'b1011 -> FORK emitted next cycle.
REQ-037 16 consecutive nonzero masks after a FORK -> state 11, sat_found=1; further messages leave it at 1 until rst_n=1.
REQ-038 FORK with valid=0 in IDLE -> stays 00; rst_n=1 during SAT -> all outputs 0 next edge.
